main_control_fsm: RTL and testbench

//  Multicycle MIPS main control unit. It decodes the 6-bit opcode from the

---
 rtl/ctrl_pkg.sv | 116 +++++++++++
 rtl/main_control_fsm_if.sv | 40 ++++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/main_control_fsm.sv | 106 ++++++++++
 tb/tb_main_control_fsm.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit: states, opcodes,
// ALUOp and datapath mux selects, plus the Moore output decode per state.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RCOMP  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

  // Unlisted controls stay 0, so every state starts from an all-zero word.
  function automatic ctrl_t decodeState(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMMSL2;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_RCOMP: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// Control bus between the main control unit (master) and the datapath (slave):
// opcode and memory-ready in, every datapath enable/select and debug state out.
interface main_control_fsm_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         i_opcode;
  logic               i_mem_ready;
  logic               o_pc_write;
  logic               o_pc_write_cond;
  logic               o_iord;
  logic               o_mem_read;
  logic               o_mem_write;
  logic               o_ir_write;
  logic               o_mem_to_reg;
  logic [1:0]         o_pc_source;
  logic [1:0]         o_alu_op;
  logic               o_alu_src_a;
  logic [1:0]         o_alu_src_b;
  logic               o_reg_write;
  logic               o_reg_dst;
  logic               o_illegal_op;
  logic               o_mem_err;
  logic [STATE_W-1:0] o_state;

  modport master (
    input  i_opcode, i_mem_ready,
    output o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write,
           o_ir_write, o_mem_to_reg, o_pc_source, o_alu_op, o_alu_src_a,
           o_alu_src_b, o_reg_write, o_reg_dst, o_illegal_op, o_mem_err,
           o_state
  );

  modport slave (
    output i_opcode, i_mem_ready,
    input  o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write,
           o_ir_write, o_mem_to_reg, o_pc_source, o_alu_op, o_alu_src_a,
           o_alu_src_b, o_reg_write, o_reg_dst, o_illegal_op, o_mem_err,
           o_state
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state; o_timeout flags the
// last permitted wait cycle (count == MEM_TIMEOUT-1).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_count_en,
  input  logic i_clear,
  output logic o_timeout
);
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // The limit cycle always ends in success or abort, both of which clear,
  // so the count never runs past LIMIT.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_count_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_timeout = (r_count == LIMIT);
endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM with memory-ready stretching and timeout abort.
// Define ADDI_EN to decode addi (001000) through the ADDIEX/ADDIWB states.
module main_control_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int STATE_W     = 4
) (
  input logic               clk,
  input logic               reset,
  main_control_fsm_if.master bus
);
  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;
  logic [5:0] r_opcode;
  logic       w_mem_state;
  logic       w_timeout;
  logic       w_abort;
  logic       w_illegal;
  logic       w_clear;
  logic       w_fetch_hold;

  assign w_mem_state  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_abort      = w_mem_state && !bus.i_mem_ready && w_timeout;
  assign w_fetch_hold = (r_state == S_FETCH) && !bus.i_mem_ready;
  assign w_clear      = bus.i_mem_ready || w_abort || (w_next != r_state);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_count_en(w_mem_state && !bus.i_mem_ready),
    .i_clear   (w_clear),
    .o_timeout (w_timeout)
  );

  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: w_next = bus.i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.i_opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
`ifdef ADDI_EN
          OP_ADDI:      w_next = S_ADDIEX;
`endif
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = bus.i_mem_ready ? S_MEMWB : (w_abort ? S_FETCH : S_MEMRD);
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = (bus.i_mem_ready || w_abort) ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_RCOMP;
      S_RCOMP:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
`ifdef ADDI_EN
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  // Controls are registered from the next state, so r_ctrl always matches r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_ctrl   <= decodeState(S_FETCH);
      r_opcode <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= decodeState(w_next);
      if (r_state == S_DECODE) begin
        r_opcode <= bus.i_opcode;
      end
    end
  end

  assign bus.o_pc_write      = !reset && r_ctrl.pc_write && !w_fetch_hold;
  assign bus.o_ir_write      = !reset && r_ctrl.ir_write && !w_fetch_hold;
  assign bus.o_mem_write     = !reset && r_ctrl.mem_write && !w_abort;
  assign bus.o_pc_write_cond = !reset && r_ctrl.pc_write_cond;
  assign bus.o_iord          = !reset && r_ctrl.iord;
  assign bus.o_mem_read      = !reset && r_ctrl.mem_read;
  assign bus.o_mem_to_reg    = !reset && r_ctrl.mem_to_reg;
  assign bus.o_alu_src_a     = !reset && r_ctrl.alu_src_a;
  assign bus.o_reg_write     = !reset && r_ctrl.reg_write;
  assign bus.o_reg_dst       = !reset && r_ctrl.reg_dst;
  assign bus.o_pc_source     = reset ? 2'b00 : r_ctrl.pc_source;
  assign bus.o_alu_op        = reset ? 2'b00 : r_ctrl.alu_op;
  assign bus.o_alu_src_b     = reset ? 2'b00 : r_ctrl.alu_src_b;
  assign bus.o_illegal_op    = !reset && w_illegal;
  assign bus.o_mem_err       = !reset && w_abort;
  assign bus.o_state         = reset ? '0 : STATE_W'(r_state);
endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm built with MEM_TIMEOUT=4; checks reset,
// every instruction path, opcode latching, memory wait limit and timeout abort.
module tb_main_control_fsm;
  logic clk;
  logic reset;
  int   cmpCount;
  int   errCount;

  main_control_fsm_if #(.STATE_W(4)) bus ();

  main_control_fsm #(
    .MEM_TIMEOUT(4),
    .STATE_W    (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [21:0] allOut;
  assign allOut = {bus.o_pc_write, bus.o_pc_write_cond, bus.o_iord, bus.o_mem_read,
                   bus.o_mem_write, bus.o_ir_write, bus.o_mem_to_reg, bus.o_pc_source,
                   bus.o_alu_op, bus.o_alu_src_a, bus.o_alu_src_b, bus.o_reg_write,
                   bus.o_reg_dst, bus.o_illegal_op, bus.o_mem_err, bus.o_state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge and are checked 1 time unit later.
  task automatic applyStimulus(input logic [5:0] op, input logic rdy);
    @(negedge clk);
    bus.i_opcode    = op;
    bus.i_mem_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    cmpCount++;
    assert (observed === expected)
    else begin
      errCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cmpCount        = 0;
    errCount        = 0;
    reset           = 1'b1;
    bus.i_opcode    = 6'd0;
    bus.i_mem_ready = 1'b0;

    repeat (3) begin
      applyStimulus(6'b000000, 1'b0);
      checkOutput("rst_all_zero", 32'(allOut), 32'd0);
    end
    reset = 1'b0;
    #1;
    checkOutput("rel_state", 32'(bus.o_state), 32'd0);
    checkOutput("rel_mem_read", 32'(bus.o_mem_read), 32'd1);
    checkOutput("rel_ir_write", 32'(bus.o_ir_write), 32'd0);
    checkOutput("rel_pc_write", 32'(bus.o_pc_write), 32'd0);

    // R-type: 0,1,6,7,0
    applyStimulus(6'b000000, 1'b1);
    checkOutput("fetch_ir_write", 32'(bus.o_ir_write), 32'd1);
    checkOutput("fetch_pc_write", 32'(bus.o_pc_write), 32'd1);
    checkOutput("fetch_src_b", 32'(bus.o_alu_src_b), 32'd1);
    applyStimulus(6'b000000, 1'b1);
    checkOutput("r_decode_state", 32'(bus.o_state), 32'd1);
    checkOutput("r_decode_src_b", 32'(bus.o_alu_src_b), 32'd3);
    checkOutput("r_decode_alu_op", 32'(bus.o_alu_op), 32'd0);
    applyStimulus(6'b000000, 1'b1);
    checkOutput("r_exec_state", 32'(bus.o_state), 32'd6);
    checkOutput("r_exec_alu_op", 32'(bus.o_alu_op), 32'd2);
    checkOutput("r_exec_src_a", 32'(bus.o_alu_src_a), 32'd1);
    checkOutput("r_exec_reg_write", 32'(bus.o_reg_write), 32'd0);
    applyStimulus(6'b000000, 1'b1);
    checkOutput("r_rcomp_state", 32'(bus.o_state), 32'd7);
    checkOutput("r_rcomp_reg_write", 32'(bus.o_reg_write), 32'd1);
    checkOutput("r_rcomp_reg_dst", 32'(bus.o_reg_dst), 32'd1);
    checkOutput("r_rcomp_alu_op", 32'(bus.o_alu_op), 32'd0);

    // lw with two wait cycles in MEMRD: 0,1,2,3,3,3,4,0
    applyStimulus(6'b100011, 1'b1);
    checkOutput("lw_fetch_state", 32'(bus.o_state), 32'd0);
    applyStimulus(6'b100011, 1'b1);
    checkOutput("lw_decode_state", 32'(bus.o_state), 32'd1);
    applyStimulus(6'b111111, 1'b0);
    checkOutput("lw_memadr_state", 32'(bus.o_state), 32'd2);
    checkOutput("lw_memadr_src_b", 32'(bus.o_alu_src_b), 32'd2);
    checkOutput("lw_memadr_src_a", 32'(bus.o_alu_src_a), 32'd1);
    applyStimulus(6'b111111, 1'b0);
    checkOutput("lw_memrd_state", 32'(bus.o_state), 32'd3);
    checkOutput("lw_memrd_read", 32'(bus.o_mem_read), 32'd1);
    checkOutput("lw_memrd_iord", 32'(bus.o_iord), 32'd1);
    applyStimulus(6'b111111, 1'b0);
    checkOutput("lw_memrd_wait2", 32'(bus.o_state), 32'd3);
    applyStimulus(6'b111111, 1'b1);
    checkOutput("lw_memrd_done", 32'(bus.o_state), 32'd3);
    applyStimulus(6'b111111, 1'b1);
    checkOutput("lw_memwb_state", 32'(bus.o_state), 32'd4);
    checkOutput("lw_memwb_mem_to_reg", 32'(bus.o_mem_to_reg), 32'd1);
    checkOutput("lw_memwb_reg_write", 32'(bus.o_reg_write), 32'd1);
    checkOutput("lw_memwb_reg_dst", 32'(bus.o_reg_dst), 32'd0);

    // sw with memory stuck: opcode changed after DECODE must not matter
    applyStimulus(6'b101011, 1'b1);
    checkOutput("sw_fetch_state", 32'(bus.o_state), 32'd0);
    applyStimulus(6'b101011, 1'b0);
    checkOutput("sw_decode_state", 32'(bus.o_state), 32'd1);
    applyStimulus(6'b100011, 1'b0);
    checkOutput("sw_memadr_state", 32'(bus.o_state), 32'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'b100011, 1'b0);
      checkOutput("sw_memwr_state", 32'(bus.o_state), 32'd5);
      checkOutput("sw_memwr_write", 32'(bus.o_mem_write), 32'd1);
      checkOutput("sw_memwr_no_err", 32'(bus.o_mem_err), 32'd0);
    end
    applyStimulus(6'b100011, 1'b0);
    checkOutput("sw_abort_state", 32'(bus.o_state), 32'd5);
    checkOutput("sw_abort_mem_err", 32'(bus.o_mem_err), 32'd1);
    checkOutput("sw_abort_no_write", 32'(bus.o_mem_write), 32'd0);
    applyStimulus(6'b000100, 1'b0);
    checkOutput("sw_after_state", 32'(bus.o_state), 32'd0);
    checkOutput("sw_after_mem_err", 32'(bus.o_mem_err), 32'd0);
    checkOutput("sw_after_ir_write", 32'(bus.o_ir_write), 32'd0);

    // beq: 0,1,8,0
    applyStimulus(6'b000100, 1'b1);
    applyStimulus(6'b000100, 1'b1);
    checkOutput("beq_decode_state", 32'(bus.o_state), 32'd1);
    applyStimulus(6'b000100, 1'b1);
    checkOutput("beq_branch_state", 32'(bus.o_state), 32'd8);
    checkOutput("beq_alu_op", 32'(bus.o_alu_op), 32'd1);
    checkOutput("beq_pc_write_cond", 32'(bus.o_pc_write_cond), 32'd1);
    checkOutput("beq_pc_source", 32'(bus.o_pc_source), 32'd1);
    checkOutput("beq_pc_write", 32'(bus.o_pc_write), 32'd0);

    // j: 0,1,9,0
    applyStimulus(6'b000010, 1'b1);
    checkOutput("j_fetch_state", 32'(bus.o_state), 32'd0);
    applyStimulus(6'b000010, 1'b1);
    checkOutput("j_decode_state", 32'(bus.o_state), 32'd1);
    applyStimulus(6'b000010, 1'b1);
    checkOutput("j_jump_state", 32'(bus.o_state), 32'd9);
    checkOutput("j_pc_write", 32'(bus.o_pc_write), 32'd1);
    checkOutput("j_pc_source", 32'(bus.o_pc_source), 32'd2);

    // Illegal opcode 111111
    applyStimulus(6'b111111, 1'b1);
    checkOutput("ill_fetch_state", 32'(bus.o_state), 32'd0);
    applyStimulus(6'b111111, 1'b1);
    checkOutput("ill_decode_state", 32'(bus.o_state), 32'd1);
    checkOutput("ill_pulse", 32'(bus.o_illegal_op), 32'd1);
    applyStimulus(6'b001000, 1'b1);
    checkOutput("ill_next_state", 32'(bus.o_state), 32'd0);
    checkOutput("ill_pulse_end", 32'(bus.o_illegal_op), 32'd0);

    // addi
    applyStimulus(6'b001000, 1'b1);
    checkOutput("addi_decode_state", 32'(bus.o_state), 32'd1);
`ifdef ADDI_EN
    checkOutput("addi_no_illegal", 32'(bus.o_illegal_op), 32'd0);
    applyStimulus(6'b100011, 1'b1);
    checkOutput("addi_ex_state", 32'(bus.o_state), 32'd10);
    checkOutput("addi_ex_src_b", 32'(bus.o_alu_src_b), 32'd2);
    applyStimulus(6'b100011, 1'b1);
    checkOutput("addi_wb_state", 32'(bus.o_state), 32'd11);
    checkOutput("addi_wb_reg_write", 32'(bus.o_reg_write), 32'd1);
    checkOutput("addi_wb_reg_dst", 32'(bus.o_reg_dst), 32'd0);
    applyStimulus(6'b100011, 1'b1);
    checkOutput("addi_end_state", 32'(bus.o_state), 32'd0);
`else
    checkOutput("addi_illegal", 32'(bus.o_illegal_op), 32'd1);
    applyStimulus(6'b100011, 1'b1);
    checkOutput("addi_end_state", 32'(bus.o_state), 32'd0);
`endif

    // lw where ready arrives on the limit cycle counts as success
    applyStimulus(6'b100011, 1'b1);
    checkOutput("lim_decode_state", 32'(bus.o_state), 32'd1);
    applyStimulus(6'b100011, 1'b0);
    checkOutput("lim_memadr_state", 32'(bus.o_state), 32'd2);
    repeat (3) begin
      applyStimulus(6'b100011, 1'b0);
      checkOutput("lim_memrd_wait", 32'(bus.o_state), 32'd3);
    end
    applyStimulus(6'b100011, 1'b1);
    checkOutput("lim_memrd_state", 32'(bus.o_state), 32'd3);
    checkOutput("lim_no_err", 32'(bus.o_mem_err), 32'd0);
    applyStimulus(6'b000000, 1'b1);
    checkOutput("lim_memwb_state", 32'(bus.o_state), 32'd4);
    applyStimulus(6'b000000, 1'b1);
    checkOutput("lim_end_state", 32'(bus.o_state), 32'd0);

    // Reset asserted mid-instruction forces outputs low at once
    applyStimulus(6'b000000, 1'b1);
    checkOutput("mid_decode_state", 32'(bus.o_state), 32'd1);
    applyStimulus(6'b000000, 1'b1);
    checkOutput("mid_exec_state", 32'(bus.o_state), 32'd6);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_zero", 32'(allOut), 32'd0);
    applyStimulus(6'b000000, 1'b1);
    checkOutput("mid_rst_hold", 32'(allOut), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("mid_rel_state", 32'(bus.o_state), 32'd0);
    checkOutput("mid_rel_ir_write", 32'(bus.o_ir_write), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end
endmodule
